fpu_mant_mult: RTL and testbench

- Iterative 24x24 unsigned mantissa multiplier in the EX stage.
- Sits directly upstream of the FPU. It consumes the same single-precision operands and produces the 48-bit significand product on the FPU's mult_result input.
- Processes BITS_PER_CYCLE bits of opb's mantissa per cycle (shift-add, radix 2^BITS_PER_CYCLE), so the full product takes multiple cycles with a start/busy/valid handshake.

---
 rtl/fpu_mant_mult.sv | 109 ++++++++++
 tb/tb_fpu_mant_mult.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mant_mult.sv
// Iterative 24x24 unsigned mantissa multiplier feeding the FPU's mult_result input.
// Retires BITS_PER_CYCLE bits of opb's mantissa per cycle with a start/busy/valid handshake.
module fpu_mant_mult #(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        new_input,
  input  logic        flush,
  output logic [47:0] mult_result,
  output logic        mult_valid,
  output logic        mult_busy
);

  localparam int unsigned MAN_W  = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned ITER   = MAN_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  if ((BITS_PER_CYCLE == 0) || (MAN_W % BITS_PER_CYCLE != 0)) begin : g_bad_param
    $error("fpu_mant_mult: BITS_PER_CYCLE must divide 24");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [MAN_W-1:0]    man_a;
  logic [MAN_W-1:0]    man_b;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;

  logic [MAN_W-1:0]          man_a_c;
  logic [MAN_W-1:0]          man_b_c;
  logic                      accept_c;
  int unsigned               shamt_c;
  logic [BITS_PER_CYCLE-1:0] digit_c;
  logic [PROD_W-1:0]         partial_c;
  logic [PROD_W-1:0]         acc_sum_c;
  logic                      unused_sign;

  // Hidden bit is set for any nonzero exponent, so Inf/NaN are treated as normals.
  function automatic logic [MAN_W-1:0] mantissa(input logic [30:0] f);
    return {(f[30:23] != 8'd0), f[22:0]};
  endfunction

  assign man_a_c     = mantissa(opa[30:0]);
  assign man_b_c     = mantissa(opb[30:0]);
  assign unused_sign = opa[31] ^ opb[31];
  assign accept_c    = new_input && !flush;
  assign mult_busy   = (state == RUN);

  // One radix-2^B digit of man_b times man_a, aligned to its weight.
  always_comb begin
    shamt_c   = 32'(cnt) * BITS_PER_CYCLE;
    digit_c   = BITS_PER_CYCLE'(man_b >> shamt_c);
    partial_c = (PROD_W'(man_a) * PROD_W'(digit_c)) << shamt_c;
    acc_sum_c = acc + partial_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      man_a       <= '0;
      man_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      mult_result <= '0;
      mult_valid  <= 1'b0;
    end else begin
      mult_valid <= 1'b0;
      case (state)
        // DONE behaves like IDLE for acceptance, allowing gap-free restarts.
        IDLE, DONE: begin
          if (accept_c) begin
            man_a <= man_a_c;
            man_b <= man_b_c;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= acc_sum_c;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              mult_result <= acc_sum_c;
              mult_valid  <= 1'b1;
              state       <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mant_mult.sv
// Directed bench for fpu_mant_mult: default radix plus B=1/8/24 instances for latency
// and product agreement against a plain 24x24 reference multiply.
module tb_fpu_mant_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_input;
  logic        flush;
  logic [31:0] opa;
  logic [31:0] opb;

  logic [47:0] res4, res1, res8, res24;
  logic        v4, v1, v8, v24;
  logic        b4, b1, b8, b24;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_mant_mult #(.BITS_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .new_input(new_input), .flush(flush),
    .mult_result(res4), .mult_valid(v4), .mult_busy(b4));
  fpu_mant_mult #(.BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .new_input(new_input), .flush(flush),
    .mult_result(res1), .mult_valid(v1), .mult_busy(b1));
  fpu_mant_mult #(.BITS_PER_CYCLE(8)) u_b8 (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .new_input(new_input), .flush(flush),
    .mult_result(res8), .mult_valid(v8), .mult_busy(b8));
  fpu_mant_mult #(.BITS_PER_CYCLE(24)) u_b24 (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .new_input(new_input), .flush(flush),
    .mult_result(res24), .mult_valid(v24), .mult_busy(b24));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [23:0] ma;
    logic [23:0] mb;
    ma = {(a[30:23] != 8'd0), a[22:0]};
    mb = {(b[30:23] != 8'd0), b[22:0]};
    return 48'(ma) * 48'(mb);
  endfunction

  // Request for one cycle, then scramble the operand bus to prove latching.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    opa = a;
    opb = b;
    new_input = 1'b1;
    tick();
    new_input = 1'b0;
    opa = 32'hDEADBEEF;
    opb = 32'h12345678;
  endtask

  task automatic wait_valid(input string tag, input logic [47:0] exp, input int exp_lat);
    int c = 1;
    bit busy_ok = 1'b1;
    while (!v4 && c < 40) begin
      if (!b4) busy_ok = 1'b0;
      tick();
      c++;
    end
    check({tag, " valid"}, 64'(v4), 64'd1);
    check({tag, " latency"}, 64'(c), 64'(exp_lat));
    check({tag, " result"}, 64'(res4), 64'(exp));
    check({tag, " busy_window"}, 64'({busy_ok, b4}), 64'b10);
  endtask

  task automatic run_all(input string tag, input logic [31:0] a, input logic [31:0] b);
    int l4 = -1, l1 = -1, l8 = -1, l24 = -1;
    logic [47:0] r4 = '0, r1 = '0, r8 = '0, r24 = '0;
    logic [47:0] exp;
    exp = ref_prod(a, b);
    opa = a;
    opb = b;
    new_input = 1'b1;
    tick();
    new_input = 1'b0;
    opa = ~a;
    opb = ~b;
    for (int c = 1; c <= 30; c++) begin
      if (v4 && l4 < 0)   begin l4 = c;  r4 = res4;  end
      if (v1 && l1 < 0)   begin l1 = c;  r1 = res1;  end
      if (v8 && l8 < 0)   begin l8 = c;  r8 = res8;  end
      if (v24 && l24 < 0) begin l24 = c; r24 = res24; end
      if (l1 >= 0 && l4 >= 0 && l8 >= 0 && l24 >= 0) break;
      tick();
    end
    check({tag, " B4 lat"}, 64'(l4), 64'd7);
    check({tag, " B1 lat"}, 64'(l1), 64'd25);
    check({tag, " B8 lat"}, 64'(l8), 64'd4);
    check({tag, " B24 lat"}, 64'(l24), 64'd2);
    check({tag, " B4 prod"}, 64'(r4), 64'(exp));
    check({tag, " B1 prod"}, 64'(r1), 64'(exp));
    check({tag, " B8 prod"}, 64'(r8), 64'(exp));
    check({tag, " B24 prod"}, 64'(r24), 64'(exp));
  endtask

  logic [31:0] bb_a [3] = '{32'h3FC00000, 32'h3F800000, 32'h00400000};
  logic [31:0] bb_b [3] = '{32'h40000000, 32'h3FFFFFFF, 32'h3FC00000};
  logic [47:0] bb_p [3] = '{48'h600000000000, 48'h7FFFFF800000, 48'h300000000000};

  initial begin
    int c;
    bit seen;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1;
    new_input = 1'b0;
    flush = 1'b0;
    opa = '0;
    opb = '0;
    tick();
    tick();
    check("reset valid", 64'(v4), 64'd0);
    check("reset busy", 64'(b4), 64'd0);
    check("reset result", 64'(res4), 64'd0);
    rst = 1'b0;
    tick();

    start_op(32'h3FC00000, 32'h3FC00000);
    wait_valid("1.5x1.5", 48'h900000000000, 7);
    tick();
    check("valid one-cycle pulse", 64'(v4), 64'd0);
    check("result held in idle", 64'(res4), 64'h900000000000);

    start_op(32'h3FFFFFFF, 32'h3FFFFFFF);
    wait_valid("max", 48'hFFFFFE000001, 7);
    start_op(32'h00000001, 32'h3F800000);
    wait_valid("denormal", 48'h000000800000, 7);
    start_op(32'h00000000, 32'h3FC00000);
    wait_valid("zero", 48'h0, 7);
    tick();

    // new_input held high: next operand set sits on the bus during RUN and is taken in DONE.
    opa = bb_a[0];
    opb = bb_b[0];
    new_input = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        opa = bb_a[i+1];
        opb = bb_b[i+1];
      end else begin
        opa = 32'h3FFFFFFF;
        opb = 32'h3FFFFFFF;
      end
      c = 1;
      while (!v4 && c < 40) begin
        tick();
        c++;
      end
      check($sformatf("b2b%0d spacing", i), 64'(c), 64'd7);
      check($sformatf("b2b%0d result", i), 64'(res4), 64'(bb_p[i]));
      if (i == 2) new_input = 1'b0;
      tick();
      if (i < 2) check($sformatf("b2b%0d restart busy", i), 64'(b4), 64'd1);
    end
    check("b2b end idle", 64'(b4), 64'd0);

    start_op(32'h3FC00000, 32'h3FC00000);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush run busy", 64'(b4), 64'd0);
    check("flush run valid", 64'(v4), 64'd0);
    check("flush run result kept", 64'(res4), 64'h300000000000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (v4) seen = 1'b1;
      tick();
    end
    check("flush no late valid", 64'(seen), 64'd0);
    start_op(32'h3F800000, 32'h3F800000);
    wait_valid("1.0x1.0", 48'h400000000000, 7);

    new_input = 1'b1;
    flush = 1'b1;
    opa = 32'h3FC00000;
    opb = 32'h3FC00000;
    tick();
    check("flush in done blocks restart", 64'(b4), 64'd0);
    check("flush in done result", 64'(res4), 64'h400000000000);
    tick();
    check("flush in idle blocks accept", 64'(b4), 64'd0);
    new_input = 1'b0;
    flush = 1'b0;
    tick();

    start_op(32'h3FFFFFFF, 32'h3FFFFFFF);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-run reset result", 64'(res4), 64'd0);
    check("mid-run reset valid", 64'(v4), 64'd0);
    check("mid-run reset busy", 64'(b4), 64'd0);
    start_op(32'h3FC00000, 32'h3FC00000);
    wait_valid("after reset", 48'h900000000000, 7);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_all("p 1.5x1.5", 32'h3FC00000, 32'h3FC00000);
    run_all("p max", 32'h3FFFFFFF, 32'h3FFFFFFF);
    run_all("p denormal", 32'h00000001, 32'h3F800000);
    run_all("p zero", 32'h00000000, 32'h3FC00000);
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) ra[30:23] = 8'h00;
      if (i % 5 == 0) rb[30:23] = 8'h00;
      run_all($sformatf("rand%0d", i), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
